// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state encoding and default sizes.
package mult_div_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem, quo} left, trial-subtract the divisor.
module mult_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_rq,
    input  logic [WIDTH-1:0]   i_dvsr,
    output logic [2*WIDTH-1:0] o_rq
);

    logic [WIDTH:0] w_shift_rem;
    logic [WIDTH:0] w_trial;

    // The partial remainder needs one extra bit: 2*rem+1 can exceed WIDTH bits when the divisor is large.
    always_comb begin
        w_shift_rem = i_rq[2*WIDTH-1:WIDTH-1];
        w_trial     = w_shift_rem - {1'b0, i_dvsr};
        if (w_trial[WIDTH]) begin
            o_rq = {w_shift_rem[WIDTH-1:0], i_rq[WIDTH-2:0], 1'b0};
        end else begin
            o_rq = {w_trial[WIDTH-1:0], i_rq[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider feeding the HI/LO registers.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_sign_a;
    logic               r_sign_b;

    logic [WIDTH:0]     w_upper_ext;
    logic [WIDTH:0]     w_mcand_ext;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_rq_next;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_last;

    assign w_abs_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_abs_b   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_quo + WIDTH'(1)) : r_quo;
    assign w_rem_fix = r_sign_a ? (~r_rem + WIDTH'(1)) : r_rem;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Booth step, summed one bit wider so a most-negative multiplicand cannot overflow the upper half.
    always_comb begin
        w_upper_ext = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
        w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper_ext + w_mcand_ext;
            2'b10:   w_sum = w_upper_ext - w_mcand_ext;
            default: w_sum = w_upper_ext;
        endcase
        w_acc_next = {w_sum, r_acc[WIDTH:1]};
    end

    mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rq   ({r_rem, r_quo}),
        .i_dvsr (r_dvsr),
        .o_rq   (w_rq_next)
    );

    // Control FSM with registered hi/lo/busy/ready/div_zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {(2*WIDTH+1){1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_dvsr   <= {WIDTH{1'b0}};
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            ready    <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mult_start) begin
                        r_state <= ST_MULT;
                        r_acc   <= {{WIDTH{1'b0}}, b, 1'b0};
                        r_mcand <= a;
                        r_cnt   <= {CNT_W{1'b0}};
                        busy    <= 1'b1;
                    end else if (div_start) begin
                        if (b == {WIDTH{1'b0}}) begin
                            r_state  <= ST_DONE;
                            ready    <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            r_state  <= ST_DIV;
                            r_rem    <= {WIDTH{1'b0}};
                            r_quo    <= w_abs_a;
                            r_dvsr   <= w_abs_b;
                            r_sign_a <= a[WIDTH-1];
                            r_sign_b <= b[WIDTH-1];
                            r_cnt    <= {CNT_W{1'b0}};
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        hi      <= w_acc_next[2*WIDTH:WIDTH+1];
                        lo      <= w_acc_next[WIDTH:1];
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                    end
                end
                ST_DIV: begin
                    {r_rem, r_quo} <= w_rq_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_DONE;
                    hi      <= w_rem_fix;
                    lo      <= w_quo_fix;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
